cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Shares the single 64-bit burst memory port of mp4 between the I-cache (line reads only) and the D-cache (line reads and write-backs).
- Each cache presents a 256-bit cacheline request. The arbiter grants one requester, runs a 4-beat burst, and returns a one-cycle line response.
- Replaces the separate cacheline adapters. Sits between both caches and the top-level mem_* ports.

Parameters:
BEATS, 4, 64-bit beats per cacheline
BEAT_WIDTH, 64, burst data width
LINE_WIDTH, 256, cacheline width; must equal BEATS*BEAT_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_line_read  in  1  I-cache line read request; held until i_line_resp
i_line_addr  in  32  I-cache line address
i_line_rdata  out  256  line data; valid only while i_line_resp=1
i_line_resp  out  1  one-cycle completion pulse to I-cache
d_line_read  in  1  D-cache line read request
d_line_write  in  1  D-cache line write-back request
d_line_addr  in  32  D-cache line address
d_line_wdata  in  256  write-back line
d_line_rdata  out  256  line data; valid only while d_line_resp=1
d_line_resp  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  burst read to memory
mem_write  out  1  burst write to memory
mem_addr  out  32  burst address, low 5 bits zero
mem_wdata  out  64  current write beat
mem_rdata  in  64  current read beat
mem_resp  in  1  beat strobe from memory; high for each of 4 beats

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - all *_resp, mem_read, mem_write = 0
  - mem_addr, mem_wdata, line buffer, *_rdata = 0
  - state = IDLE, beat counter = 0, last_grant = I
- States: IDLE, I_READ, D_READ, D_WRITE, RESP.
- IDLE grant rules:
  - Only I pending: go to I_READ.
  - Only D pending: go to D_WRITE if d_line_write, else D_READ.
  - Both pending: grant the requester that is not last_grant. Update last_grant on every grant.
  - On grant, latch {addr[31:5],5'b0} into mem_addr. For D_WRITE, also latch d_line_wdata.
- I_READ / D_READ:
  - mem_read=1 held continuously.
  - On each mem_resp, store mem_rdata in buffer bits [64*cnt+63 : 64*cnt], then cnt++.
  - Beat 0 is the lowest address (bits 63:0).
  - When cnt==3 and mem_resp=1, go to RESP.
- D_WRITE:
  - mem_write=1 held.
  - mem_wdata = latched line bits [64*cnt+63 : 64*cnt], combinational from cnt.
  - cnt++ on each mem_resp. Go to RESP after the 4th mem_resp.
- Beat cycles need not be consecutive. Cycles with mem_resp=0 hold cnt and the outputs.
- RESP:
  - mem_read = mem_write = 0.
  - Assert the granted requester's *_resp for exactly one cycle, with *_rdata = buffer (reads). A write response carries no data meaning.
  - cnt is reset. Next state is IDLE unconditionally.
  - No grant is issued in RESP. A cache that drops its request after resp is never double-served.
- Latency: request seen in IDLE at cycle 0 → mem_read/mem_write high at cycle 1. With memory beats at cycles 1–4, *_resp is at cycle 5. The minimum turnaround to the next grant is 1 cycle (the IDLE cycle).
- The non-granted requester waits with its request held. No output toggles toward it.
- Requests changing mid-burst (address, data, or deassert) are ignored. Latched values are used.
- d_line_read and d_line_write both high is illegal. Write wins; a simulation assertion fires.
- mem_resp received in IDLE or RESP is ignored.
- rst mid-burst: return to IDLE at the next edge with all outputs at reset values. No response is issued for the aborted request.

Test Plan:
- I-only read of addr 0x0000_0064: mem_addr=0x0000_0060, mem_read high cycles 1–4; beats 0x11..,0x22..,0x33..,0x44.. → i_line_rdata={0x44..,0x33..,0x22..,0x11..}, i_line_resp pulse at cycle 5 only, d_line_resp=0.
- D write-back of addr 0x8000_01E0 with line words W0..W3: mem_write high; mem_wdata=W0,W1,W2,W3 on the successive mem_resp beats; d_line_resp single pulse; mem_write low in RESP.
- Simultaneous I read and D read after reset → D granted first (last_grant=I). I is served next with exactly 1 IDLE cycle between bursts. Then a second contention → D again, proving alternation.
- Memory inserts 2 idle cycles between beats 1 and 2 → data lands in the correct 64-bit slices; resp timing shifts by 2 cycles.
- rst asserted after beat 2 of a D read → next cycle all outputs 0 and state IDLE. A held I request is then granted normally.
- d_line_addr changed mid-burst from 0x100 to 0x200 → mem_addr stays 0x100 throughout the burst.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Brief    : Shares one 64-bit burst memory port between the I-cache and
//            D-cache, converting 256-bit line requests into 4-beat bursts.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int BEATS      = 4,
  parameter int BEAT_WIDTH = 64,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_line_read,
  input  logic [31:0]           i_line_addr,
  output logic [LINE_WIDTH-1:0] i_line_rdata,
  output logic                  i_line_resp,
  input  logic                  d_line_read,
  input  logic                  d_line_write,
  input  logic [31:0]           d_line_addr,
  input  logic [LINE_WIDTH-1:0] d_line_wdata,
  output logic [LINE_WIDTH-1:0] d_line_rdata,
  output logic                  d_line_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int c_cnt_w = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int c_off_w = $clog2(LINE_WIDTH / 8);
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);
  localparam logic [31:0] c_addr_mask = ~((32'd1 << c_off_w) - 32'd1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_READ  = 3'd1,
    D_READ  = 3'd2,
    D_WRITE = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_last_grant;  // 0 = I-cache, 1 = D-cache; also the current grantee
  logic [31:0]           r_mem_addr;
  logic [LINE_WIDTH-1:0] r_line;        // read fill buffer, or latched write-back line

  logic        w_i_req;
  logic        w_d_req;
  logic        w_grant;
  logic        w_grant_d;
  logic        w_busy;
  logic        w_reading;
  logic [31:0] w_sel_addr;

  assign w_i_req   = i_line_read;
  assign w_d_req   = d_line_read | d_line_write;
  assign w_reading = (r_state == I_READ) || (r_state == D_READ);
  assign w_busy    = w_reading || (r_state == D_WRITE);
  assign w_sel_addr = w_grant_d ? d_line_addr : i_line_addr;

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_req || w_d_req) begin
          w_grant = 1'b1;
          // Under contention the requester that was not served last wins.
          w_grant_d = w_d_req && (!w_i_req || !r_last_grant);
          if (w_grant_d) w_state_next = d_line_write ? D_WRITE : D_READ;
          else           w_state_next = I_READ;
        end
      end
      I_READ, D_READ, D_WRITE: begin
        if (mem_resp && (r_cnt == c_last_beat)) w_state_next = RESP;
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b0;
      r_mem_addr   <= '0;
      r_line       <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_last_grant <= w_grant_d;
        r_mem_addr   <= w_sel_addr & c_addr_mask;
        if (w_grant_d && d_line_write) r_line <= d_line_wdata;
      end
      if (w_reading && mem_resp) r_line[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
      if (w_busy && mem_resp) r_cnt <= r_cnt + 1'b1;
      else if (r_state == RESP) r_cnt <= '0;
    end
  end

  assign mem_read    = w_reading;
  assign mem_write   = (r_state == D_WRITE);
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = mem_write ? r_line[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] : '0;
  // Responses and line data are gated so the waiting requester sees nothing move.
  assign i_line_resp  = (r_state == RESP) && !r_last_grant;
  assign d_line_resp  = (r_state == RESP) &&  r_last_grant;
  assign i_line_rdata = i_line_resp ? r_line : '0;
  assign d_line_rdata = d_line_resp ? r_line : '0;

  a_d_read_write_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(d_line_read && d_line_write));

endmodule
`default_nettype wire
